imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 35 +++
 rtl/imem_arb_starve_cnt.sv | 38 +++
 rtl/imem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: FSM/owner enums and port bundles.
package imem_arbiter_pkg;

  localparam int unsigned BUS_AW = 32;

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_LOAD
  } owner_e;

  typedef struct packed {
    logic              req;
    logic [BUS_AW-1:0] addr;
  } fetch_req_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BUS_AW-1:0] addr;
    logic              done;
    logic              reboot;
  } load_req_t;

  // Data words stay outside the bundles so DATA_WIDTH remains a module parameter.
  typedef struct packed {
    logic gnt;
    logic rvalid;
  } port_rsp_t;

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Loader starvation counter: counts denied loader cycles in RUN and forces a loader
// grant once the count reaches STARVE_LIMIT.
module imem_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic run,
  input  logic l_req,
  input  logic l_gnt,
  output logic force_load
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign force_load = run && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (l_gnt) begin
      cnt_d = '0;
    end else if (run && l_req && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter between core fetch and boot loader, gated by a BOOT/RUN FSM.
// Define IMEM_ARB_STARVE_EN to bound loader starvation under fetch priority.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IMEM_SZ_IN_KB = 1,
  parameter int unsigned STARVE_LIMIT  = 4,
  localparam int unsigned AW           = $clog2(IMEM_SZ_IN_KB * 256)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  // fetch side
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  // loader side
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [31:0]           l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  input  logic                  l_done,
  input  logic                  l_reboot,
  // memory side
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  core_run
);

  fetch_req_t f_in;
  load_req_t  l_in;
  port_rsp_t  f_rsp, l_rsp;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   rd_pend_q, rd_pend_d;
  logic   force_load;

  assign f_in = '{req: f_req, addr: f_addr};
  assign l_in = '{req: l_req, we: l_we, addr: l_addr, done: l_done, reboot: l_reboot};

`ifdef IMEM_ARB_STARVE_EN
  imem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk       (clk),
    .arst_n    (arst_n),
    .run       (state_q == RUN),
    .l_req     (l_in.req),
    .l_gnt     (l_rsp.gnt),
    .force_load(force_load)
  );
`else
  assign force_load = 1'b0;
`endif

  // Grants are gated by arst_n so nothing reaches memory while reset is held.
  always_comb begin
    state_d   = state_q;
    f_rsp.gnt = 1'b0;
    l_rsp.gnt = 1'b0;
    core_run  = 1'b0;
    if (arst_n) begin
      unique case (state_q)
        BOOT: begin
          l_rsp.gnt = l_in.req;
          if (l_in.done) state_d = RUN;
        end
        RUN: begin
          core_run  = 1'b1;
          l_rsp.gnt = l_in.req & (force_load | ~f_in.req);
          f_rsp.gnt = f_in.req & ~(force_load & l_in.req);
          if (l_in.reboot) state_d = BOOT;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    owner_d   = owner_q;
    rd_pend_d = 1'b0;
    if (f_rsp.gnt) begin
      owner_d   = OWN_FETCH;
      rd_pend_d = 1'b1;
    end else if (l_rsp.gnt && !l_in.we) begin
      owner_d   = OWN_LOAD;
      rd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= BOOT;
      owner_q   <= OWN_FETCH;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign f_rsp.rvalid = rd_pend_q && (owner_q == OWN_FETCH);
  assign l_rsp.rvalid = rd_pend_q && (owner_q == OWN_LOAD);

  assign f_gnt    = f_rsp.gnt;
  assign l_gnt    = l_rsp.gnt;
  assign f_rvalid = f_rsp.rvalid;
  assign l_rvalid = l_rsp.rvalid;
  assign f_rdata  = f_rsp.rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rsp.rvalid ? mem_rdata : '0;

  assign mem_en    = f_rsp.gnt | l_rsp.gnt;
  assign mem_we    = l_rsp.gnt & l_in.we;
  assign mem_addr  = l_rsp.gnt ? l_in.addr[AW+1:2] : f_in.addr[AW+1:2];
  assign mem_wdata = l_wdata;

  // Byte-offset and above-depth address bits are dropped by design (word-aligned wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_in.addr[31:AW+2], f_in.addr[1:0],
                              l_in.addr[31:AW+2], l_in.addr[1:0]};

endmodule
